// File: rtl/int_ctrl.sv
// int_ctrl: four-source edge-triggered interrupt controller for the single-cycle CPU.
// It latches rising edges on irq as pending and qualifies them with a per-source
// mask and a global enable. The highest-priority eligible source is taken: a
// one-cycle int_take strobe with int_vec. Further takes are held off until reti.
// Ports:
//   clk, reset        - system clock (rising edge), async active-high reset
//   irq[3:0]          - request lines, edge-triggered, bit 0 highest priority
//   mask_we, mask_in  - per-source enable register load
//   gie_set, gie_clr  - global enable set/clear (clear wins)
//   reti              - return-from-interrupt strobe from uc
//   int_take          - one-cycle entry strobe (PC <= int_vec, push return PC)
//   int_vec           - vector of the source being taken
//   int_id            - index of source taken / in service
//   in_service        - high from take until reti is accepted
//   pending           - pending register
//   ie                - effective enables, mask & {4{gie}}
module int_ctrl #(
  parameter int unsigned     PC_W     = 10,
  parameter logic [PC_W-1:0] VEC_BASE = PC_W'(1008)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [3:0]      irq,
  input  logic            mask_we,
  input  logic [3:0]      mask_in,
  input  logic            gie_set,
  input  logic            gie_clr,
  input  logic            reti,
  output logic            int_take,
  output logic [PC_W-1:0] int_vec,
  output logic [1:0]      int_id,
  output logic            in_service,
  output logic [3:0]      pending,
  output logic [3:0]      ie
);

  localparam int unsigned N_SRC = 4;
  localparam int unsigned ID_W  = 2;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_TAKE    = 2'd1,
    S_SERVICE = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [N_SRC-1:0] irq_prev_q;
  logic [N_SRC-1:0] pending_q, pending_d;
  logic [N_SRC-1:0] mask_q, mask_d;
  logic             gie_q, gie_d;
  logic [ID_W-1:0]  id_q, id_d;

  logic [N_SRC-1:0] rise;
  logic [N_SRC-1:0] elig;
  logic [N_SRC-1:0] clr;
  logic [ID_W-1:0]  sel;

  // Edge detect and eligibility use the values registered before this edge
  assign rise = irq & ~irq_prev_q;
  assign elig = pending_q & mask_q & {N_SRC{gie_q}};

  // Fixed priority: lowest index wins, so scan from the top down
  always_comb begin
    sel = '0;
    for (int i = N_SRC - 1; i >= 0; i--) begin
      if (elig[i]) sel = ID_W'(i);
    end
  end

  // Next-state logic for FSM, pending, mask and global enable
  always_comb begin
    state_d = state_q;
    id_d    = id_q;
    clr     = '0;
    unique case (state_q)
      S_IDLE: begin
        if (|elig) begin
          state_d = S_TAKE;
          id_d    = sel;
          clr     = N_SRC'(1) << sel;
        end
      end
      S_TAKE:    state_d = S_SERVICE;
      S_SERVICE: if (reti) state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase

    // A new edge on the bit being cleared keeps it pending
    pending_d = (pending_q & ~clr) | rise;
    mask_d    = mask_we ? mask_in : mask_q;
    gie_d     = gie_clr ? 1'b0 : (gie_set ? 1'b1 : gie_q);
  end

  // irq_prev resets high so lines held through reset are not seen as edges
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= S_IDLE;
      irq_prev_q <= '1;
      pending_q  <= '0;
      mask_q     <= '0;
      gie_q      <= 1'b0;
      id_q       <= '0;
    end else begin
      state_q    <= state_d;
      irq_prev_q <= irq;
      pending_q  <= pending_d;
      mask_q     <= mask_d;
      gie_q      <= gie_d;
      id_q       <= id_d;
    end
  end

  // Outputs are decodes of registered state only
  assign int_take   = (state_q == S_TAKE);
  assign in_service = (state_q == S_TAKE) || (state_q == S_SERVICE);
  assign int_id     = id_q;
  assign int_vec    = VEC_BASE + PC_W'({id_q, 2'b00});
  assign pending    = pending_q;
  assign ie         = mask_q & {N_SRC{gie_q}};

endmodule
